// File: rtl/display_scan_sched_pkg.sv
// Shared definitions for the seven-segment display scan logic: state encoding,
// default geometry and the masked next-digit search.
package display_scan_sched_pkg;

  localparam int DEF_DIGITS = 8;
  localparam int DEF_SEL_W  = 3;
  localparam int MAX_DIGITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Next set bit of mask strictly above cur; falls back to the lowest set bit.
  function automatic int next_set_bit(input logic [MAX_DIGITS-1:0] mask,
                                      input int cur,
                                      input int digits);
    int lowest;
    int above;
    lowest = 0;
    above  = -1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if ((i < digits) && mask[i]) begin
        lowest = i;
        if (i > cur) begin
          above = i;
        end
      end
    end
    if (above >= 0) begin
      return above;
    end
    return lowest;
  endfunction

endpackage

// File: rtl/display_scan_sched_mask_next_index.sv
// Combinational priority search: next enabled digit after cur, with a flag set
// when the search wrapped back to an index at or below cur.
module display_scan_sched_mask_next_index
  import display_scan_sched_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic [DIGITS-1:0] digit_mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrapped
);

  logic [MAX_DIGITS-1:0] mask_ext_s;

  assign mask_ext_s = MAX_DIGITS'(digit_mask);
  assign nxt        = SEL_W'(next_set_bit(mask_ext_s, int'(cur), DIGITS));
  assign wrapped    = (nxt <= cur);

endmodule

// File: rtl/display_scan_sched.sv
// Digit scan scheduler: fixed slots per enabled digit, each opening with an
// anodes-off dead time, plus frame-counted blink blanking.
module display_scan_sched
  import display_scan_sched_pkg::*;
#(
  parameter int DIGITS       = DEF_DIGITS,
  parameter int SEL_W        = DEF_SEL_W,
  parameter int SLOT_CYC     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIGITS-1:0] digit_mask,
  input  logic [DIGITS-1:0] blink_mask,
  input  logic              blink_en,
  output logic [SEL_W-1:0]  digit_sel,
  output logic [DIGITS-1:0] an_n,
  output logic              seg_en,
  output logic              frame_start
);

  localparam int SLOT_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  scan_state_t         state_r,       state_s;
  logic [SEL_W-1:0]    sel_r,         sel_s;
  logic [SLOT_W-1:0]   slot_cnt_r,    slot_cnt_s;
  logic [FRAME_W-1:0]  frame_cnt_r,   frame_cnt_s;
  logic                phase_r,       phase_s;
  logic [DIGITS-1:0]   an_n_r,        an_n_s;
  logic                seg_en_r,      seg_en_s;
  logic                frame_start_r, frame_start_s;
  logic [SEL_W-1:0]    search_cur_s;
  logic [SEL_W-1:0]    search_nxt_s;
  logic                search_wrap_s;
  logic                hide_s;

  display_scan_sched_mask_next_index #(
    .DIGITS (DIGITS),
    .SEL_W  (SEL_W)
  ) u_next (
    .digit_mask (digit_mask),
    .cur        (search_cur_s),
    .nxt        (search_nxt_s),
    .wrapped    (search_wrap_s)
  );

  // From IDLE, search from the top index so the wrap lands on the lowest digit.
  always_comb begin
    search_cur_s = sel_r;
    if (state_r == ST_IDLE) begin
      search_cur_s = SEL_W'(DIGITS - 1);
    end else begin
      search_cur_s = sel_r;
    end
  end

  // Next-state, slot timer and frame/blink counters.
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    slot_cnt_s    = slot_cnt_r;
    frame_cnt_s   = frame_cnt_r;
    phase_s       = phase_r;
    frame_start_s = 1'b0;
    if (!enable) begin
      state_s     = ST_IDLE;
      slot_cnt_s  = '0;
      frame_cnt_s = '0;
      phase_s     = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          slot_cnt_s  = '0;
          frame_cnt_s = '0;
          phase_s     = 1'b0;
          if (digit_mask != '0) begin
            state_s       = ST_BLANK;
            sel_s         = search_nxt_s;
            frame_start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BLANK: begin
          slot_cnt_s = slot_cnt_r + SLOT_W'(1);
          if (slot_cnt_r == BLANK_LAST) begin
            state_s = ST_SHOW;
          end else begin
            state_s = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (slot_cnt_r == SLOT_LAST) begin
            slot_cnt_s = '0;
            if (digit_mask == '0) begin
              state_s     = ST_IDLE;
              frame_cnt_s = '0;
              phase_s     = 1'b0;
            end else begin
              state_s = ST_BLANK;
              sel_s   = search_nxt_s;
              if (search_wrap_s) begin
                frame_start_s = 1'b1;
                if (frame_cnt_r == FRAME_LAST) begin
                  frame_cnt_s = '0;
                  phase_s     = ~phase_r;
                end else begin
                  frame_cnt_s = frame_cnt_r + FRAME_W'(1);
                end
              end else begin
                frame_cnt_s = frame_cnt_r;
              end
            end
          end else begin
            slot_cnt_s = slot_cnt_r + SLOT_W'(1);
          end
        end
        default: begin
          state_s    = ST_IDLE;
          slot_cnt_s = '0;
        end
      endcase
    end
  end

  // Anode/segment drive for the coming cycle, registered below.
  always_comb begin
    hide_s   = blink_en & blink_mask[sel_s] & phase_s;
    an_n_s   = '1;
    seg_en_s = 1'b0;
    if ((state_s == ST_SHOW) && !hide_s) begin
      an_n_s[sel_s] = 1'b0;
      seg_en_s      = 1'b1;
    end else begin
      an_n_s   = '1;
      seg_en_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      sel_r         <= '0;
      slot_cnt_r    <= '0;
      frame_cnt_r   <= '0;
      phase_r       <= 1'b0;
      an_n_r        <= '1;
      seg_en_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      slot_cnt_r    <= slot_cnt_s;
      frame_cnt_r   <= frame_cnt_s;
      phase_r       <= phase_s;
      an_n_r        <= an_n_s;
      seg_en_r      <= seg_en_s;
      frame_start_r <= frame_start_s;
    end
  end

  assign digit_sel   = sel_r;
  assign an_n        = an_n_r;
  assign seg_en      = seg_en_r;
  assign frame_start = frame_start_r;

endmodule
